// File: rtl/imm_gen_pipe_pkg.sv
// Shared types and opcode constants for the RISC-V immediate generator.
package imm_pkg;

   // Immediate format class reported alongside each decoded immediate.
   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_R    = 3'd1,
      FMT_I    = 3'd2,
      FMT_S    = 3'd3,
      FMT_B    = 3'd4,
      FMT_U    = 3'd5,
      FMT_J    = 3'd6
   } imm_fmt_t;

   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decoder: instruction word -> immediate, format class, illegal flag.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit SIGN_EXT = 1'b1,
   parameter bit RV64_OPS = 1'b0
)
(
   input  logic [31:0]     ir,
   output logic [XLEN-1:0] imm,
   output imm_fmt_t        fmt,
   output logic            illegal
);

   logic [6:0]  opc;
   logic        s;
   logic [31:0] field;

   assign opc = ir[6:0];
   // Fill bit for the 32-bit field; forced low in legacy zero-extend mode.
   assign s   = SIGN_EXT & ir[31];

   // Widen a 32-bit field to XLEN, replicating bit 31 only in sign-extend mode.
   function automatic logic [XLEN-1:0] widen(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{SIGN_EXT & v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   // Opcode-driven field selection; unknown opcodes yield a zero immediate.
   always_comb begin
      field   = '0;
      fmt     = FMT_NONE;
      illegal = 1'b0;
      case (opc)
         OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
            field = {{20{s}}, ir[31:20]};
            fmt   = FMT_I;
         end
         OPC_OPIMM32: begin
            if (RV64_OPS) begin
               field = {{20{s}}, ir[31:20]};
               fmt   = FMT_I;
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_STORE: begin
            field = {{20{s}}, ir[31:25], ir[11:7]};
            fmt   = FMT_S;
         end
         OPC_BRANCH: begin
            if (SIGN_EXT) field = {{19{s}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            else          field = {20'b0, ir[31], ir[7], ir[30:25], ir[11:8]};
            fmt = FMT_B;
         end
         OPC_LUI, OPC_AUIPC: begin
            field = {ir[31:12], 12'b0};
            fmt   = FMT_U;
         end
         OPC_JAL: begin
            if (SIGN_EXT) field = {{11{s}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            else          field = {12'b0, ir[31], ir[19:12], ir[20], ir[30:21]};
            fmt = FMT_J;
         end
         OPC_OP: begin
            fmt = FMT_R;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
      imm = widen(field);
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: one-cycle decode into an output register
// backed by a one-entry skid register, plus a saturating illegal-opcode counter.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter bit SIGN_EXT  = 1'b1,
   parameter bit RV64_OPS  = 1'b0,
   parameter int ILL_CNT_W = 16
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_ir,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_imm,
   output imm_fmt_t             out_fmt,
   output logic [31:0]          out_ir,
   output logic                 out_illegal,
   output logic [ILL_CNT_W-1:0] ill_count
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end
   if (RV64_OPS && XLEN != 64) begin : g_bad_rv64
      $error("imm_gen_pipe: RV64_OPS requires XLEN=64");
   end

   logic [XLEN-1:0] dec_imm;
   imm_fmt_t        dec_fmt;
   logic            dec_ill;

   logic            skid_valid;
   logic [XLEN-1:0] skid_imm;
   imm_fmt_t        skid_fmt;
   logic [31:0]     skid_ir;
   logic            skid_ill;

   logic accept, pop;
   logic out_load_skid, out_load_new, skid_load;
   logic out_valid_next, skid_valid_next;

   imm_decode #(
      .XLEN     (XLEN),
      .SIGN_EXT (SIGN_EXT),
      .RV64_OPS (RV64_OPS)
   ) u_dec (
      .ir      (in_ir),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_ill)
   );

   // Handshake and steering: output refills from skid first, else from the new entry.
   always_comb begin
      accept          = in_valid && in_ready;
      pop             = out_valid && out_ready;
      out_load_skid   = skid_valid && pop;
      out_load_new    = accept && !skid_valid && (!out_valid || pop);
      skid_load       = accept && out_valid && !pop;
      out_valid_next  = out_load_skid || out_load_new || (out_valid && !pop);
      skid_valid_next = skid_load || (skid_valid && !pop);
   end

   // Valid bits and registered in_ready; flush empties both slots.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         out_valid  <= out_valid_next;
         skid_valid <= skid_valid_next;
         in_ready   <= !skid_valid_next;
      end
   end

   // Payload registers; contents only load on a transfer so they stay stable while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_imm     <= '0;
         out_fmt     <= FMT_NONE;
         out_ir      <= '0;
         out_illegal <= 1'b0;
         skid_imm    <= '0;
         skid_fmt    <= FMT_NONE;
         skid_ir     <= '0;
         skid_ill    <= 1'b0;
      end else begin
         if (out_load_skid) begin
            out_imm     <= skid_imm;
            out_fmt     <= skid_fmt;
            out_ir      <= skid_ir;
            out_illegal <= skid_ill;
         end else if (out_load_new) begin
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
            out_ir      <= in_ir;
            out_illegal <= dec_ill;
         end
         if (skid_load) begin
            skid_imm <= dec_imm;
            skid_fmt <= dec_fmt;
            skid_ir  <= in_ir;
            skid_ill <= dec_ill;
         end
      end
   end

   // Count accepted illegal instructions, holding at all-ones; a flushed input is not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ill_count <= '0;
      end else if (accept && dec_ill && !flush && (ill_count != {ILL_CNT_W{1'b1}})) begin
         ill_count <= ill_count + ILL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: three configurations (RV32 sign-extend, RV32 legacy, RV64 with
// OP-IMM-32) share one stimulus stream; a scoreboard queue checks every output transfer.
module tb_imm_gen_pipe;
   import imm_pkg::*;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] e32;
      logic [31:0] ez;
      logic [63:0] e64;
      imm_fmt_t    f32;
      imm_fmt_t    f64;
      logic        ill32;
      logic        ill64;
   } vec_t;

   localparam int NV = 13;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_ir = '0;
   logic        out_ready = 1'b0;

   logic        in_ready_a, out_valid_a, out_illegal_a;
   logic [31:0] out_imm_a, out_ir_a;
   imm_fmt_t    out_fmt_a;
   logic [3:0]  ill_count_a;

   logic        in_ready_b, out_valid_b, out_illegal_b;
   logic [31:0] out_imm_b, out_ir_b;
   imm_fmt_t    out_fmt_b;
   logic [3:0]  ill_count_b;

   logic        in_ready_c, out_valid_c, out_illegal_c;
   logic [63:0] out_imm_c;
   logic [31:0] out_ir_c;
   imm_fmt_t    out_fmt_c;
   logic [3:0]  ill_count_c;

   int checks = 0;
   int failures = 0;

   vec_t tbl [NV];
   vec_t sb [$];
   int   cnt32 = 0;
   int   cnt64 = 0;
   logic accepted;
   logic held = 1'b0;
   logic [31:0] held_imm, held_ir;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1'b1), .RV64_OPS(1'b0), .ILL_CNT_W(4)) ua (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_ir(in_ir), .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a),
      .out_fmt(out_fmt_a), .out_ir(out_ir_a), .out_illegal(out_illegal_a), .ill_count(ill_count_a));

   imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1'b0), .RV64_OPS(1'b0), .ILL_CNT_W(4)) ub (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_ir(in_ir), .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
      .out_fmt(out_fmt_b), .out_ir(out_ir_b), .out_illegal(out_illegal_b), .ill_count(ill_count_b));

   imm_gen_pipe #(.XLEN(64), .SIGN_EXT(1'b1), .RV64_OPS(1'b1), .ILL_CNT_W(4)) uc (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c),
      .in_ir(in_ir), .out_valid(out_valid_c), .out_ready(out_ready), .out_imm(out_imm_c),
      .out_fmt(out_fmt_c), .out_ir(out_ir_c), .out_illegal(out_illegal_c), .ill_count(ill_count_c));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t find(input logic [31:0] ir);
      vec_t r;
      r = tbl[8];
      for (int i = 0; i < NV; i++)
         if (tbl[i].ir == ir) r = tbl[i];
      return r;
   endfunction

   // One clock of stimulus; called just after a falling edge, returns at the next one.
   task automatic step(input logic v, input logic [31:0] ir, input logic ordy, input logic fl);
      vec_t e;
      logic acc, pop;
      in_valid  = v;
      in_ir     = ir;
      out_ready = ordy;
      flush     = fl;
      #1;
      acc = v && in_ready_a;
      pop = out_valid_a && ordy;
      accepted = acc;
      if (rst) begin
         sb.delete();
         cnt32 = 0;
         cnt64 = 0;
         held  = 1'b0;
      end else if (fl) begin
         sb.delete();
         held = 1'b0;
      end else begin
         if (held && out_valid_a) begin
            chk("stall_imm", 64'(out_imm_a), 64'(held_imm));
            chk("stall_ir", 64'(out_ir_a), 64'(held_ir));
         end
         if (pop) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got ir %h expected no transfer", out_ir_a);
            end else begin
               e = sb.pop_front();
               chk("ir_a", 64'(out_ir_a), 64'(e.ir));
               chk("imm_a", 64'(out_imm_a), 64'(e.e32));
               chk("fmt_a", 64'(out_fmt_a), 64'(e.f32));
               chk("ill_a", 64'(out_illegal_a), 64'(e.ill32));
               chk("imm_b", 64'(out_imm_b), 64'(e.ez));
               chk("vld_c", 64'(out_valid_c), 64'd1);
               chk("imm_c", out_imm_c, e.e64);
               chk("fmt_c", 64'(out_fmt_c), 64'(e.f64));
               chk("ill_c", 64'(out_illegal_c), 64'(e.ill64));
            end
         end
         if (acc) begin
            e = find(ir);
            sb.push_back(e);
            if (e.ill32 && cnt32 != 15) cnt32++;
            if (e.ill64 && cnt64 != 15) cnt64++;
         end
         held     = out_valid_a && !ordy;
         held_imm = out_imm_a;
         held_ir  = out_ir_a;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] ir, input bit rnd);
      int n;
      n = 0;
      accepted = 1'b0;
      while (!accepted && n < 50) begin
         if (rnd && $urandom_range(0, 3) == 0) step(1'b0, 32'h0, 1'($urandom_range(0, 1)), 1'b0);
         else step(1'b1, ir, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
         n++;
      end
      if (!accepted) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: got no accept for ir %h expected accept within 50 cycles", ir);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drain_left", 64'(sb.size()), 64'd0);
      chk("drain_vld", 64'(out_valid_a), 64'd0);
      chk("cnt_a", 64'(ill_count_a), 64'(cnt32));
      chk("cnt_b", 64'(ill_count_b), 64'(cnt32));
      chk("cnt_c", 64'(ill_count_c), 64'(cnt64));
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_vld_a"}, 64'(out_valid_a), 64'd0);
      chk({tag, "_rdy_a"}, 64'(in_ready_a), 64'd1);
      chk({tag, "_rdy_b"}, 64'(in_ready_b), 64'd1);
      chk({tag, "_rdy_c"}, 64'(in_ready_c), 64'd1);
      chk({tag, "_imm_a"}, 64'(out_imm_a), 64'd0);
      chk({tag, "_ir_a"}, 64'(out_ir_a), 64'd0);
      chk({tag, "_fmt_a"}, 64'(out_fmt_a), 64'(FMT_NONE));
      chk({tag, "_ill_a"}, 64'(out_illegal_a), 64'd0);
      chk({tag, "_cnt_a"}, 64'(ill_count_a), 64'd0);
      chk({tag, "_vld_c"}, 64'(out_valid_c), 64'd0);
      chk({tag, "_imm_c"}, out_imm_c, 64'd0);
      chk({tag, "_cnt_c"}, 64'(ill_count_c), 64'd0);
   endtask

   initial begin
      tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 32'h00000FFF, 64'hFFFFFFFFFFFFFFFF, FMT_I, FMT_I, 1'b0, 1'b0};
      tbl[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 32'h00000FFE, 64'hFFFFFFFFFFFFFFFC, FMT_B, FMT_B, 1'b0, 1'b0};
      tbl[2]  = '{32'h800000EF, 32'hFFF00000, 32'h00080000, 64'hFFFFFFFFFFF00000, FMT_J, FMT_J, 1'b0, 1'b0};
      tbl[3]  = '{32'h800000B7, 32'h80000000, 32'h80000000, 64'hFFFFFFFF80000000, FMT_U, FMT_U, 1'b0, 1'b0};
      tbl[4]  = '{32'hFFF0009B, 32'h00000000, 32'h00000000, 64'hFFFFFFFFFFFFFFFF, FMT_NONE, FMT_I, 1'b1, 1'b0};
      tbl[5]  = '{32'hFE512C23, 32'hFFFFFFF8, 32'h00000FF8, 64'hFFFFFFFFFFFFFFF8, FMT_S, FMT_S, 1'b0, 1'b0};
      tbl[6]  = '{32'h00B50533, 32'h00000000, 32'h00000000, 64'h0000000000000000, FMT_R, FMT_R, 1'b0, 1'b0};
      tbl[7]  = '{32'h80001073, 32'hFFFFF800, 32'h00000800, 64'hFFFFFFFFFFFFF800, FMT_I, FMT_I, 1'b0, 1'b0};
      tbl[8]  = '{32'h0000007F, 32'h00000000, 32'h00000000, 64'h0000000000000000, FMT_NONE, FMT_NONE, 1'b1, 1'b1};
      tbl[9]  = '{32'h12345297, 32'h12345000, 32'h12345000, 64'h0000000012345000, FMT_U, FMT_U, 1'b0, 1'b0};
      tbl[10] = '{32'h00452283, 32'h00000004, 32'h00000004, 64'h0000000000000004, FMT_I, FMT_I, 1'b0, 1'b0};
      tbl[11] = '{32'h7FF00067, 32'h000007FF, 32'h000007FF, 64'h00000000000007FF, FMT_I, FMT_I, 1'b0, 1'b0};
      tbl[12] = '{32'h00001863, 32'h00000010, 32'h00000008, 64'h0000000000000010, FMT_B, FMT_B, 1'b0, 1'b0};

      @(negedge clk);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'h0000007F, 1'b1, 1'b0);
      rst = 1'b0;
      reset_checks("reset");

      // Back-to-back stream, consumer always ready
      for (int i = 0; i < NV; i++) send(tbl[i].ir, 1'b0);
      drain();

      // Random valid gaps and consumer back-pressure
      for (int i = 0; i < NV; i++) send(tbl[(i * 5) % NV].ir, 1'b1);
      drain();

      // Four instructions into a stalled consumer
      step(1'b1, tbl[0].ir, 1'b0, 1'b0);
      chk("stall_acc1", 64'(accepted), 64'd1);
      step(1'b1, tbl[1].ir, 1'b0, 1'b0);
      chk("stall_acc2", 64'(accepted), 64'd1);
      chk("stall_rdy", 64'(in_ready_a), 64'd0);
      step(1'b1, tbl[2].ir, 1'b0, 1'b0);
      step(1'b1, tbl[2].ir, 1'b0, 1'b0);
      chk("stall_rdy_hold", 64'(in_ready_a), 64'd0);
      chk("stall_depth", 64'(sb.size()), 64'd2);
      step(1'b1, tbl[2].ir, 1'b1, 1'b0);
      chk("unstall_rdy", 64'(in_ready_a), 64'd1);
      chk("unstall_vld", 64'(out_valid_a), 64'd1);
      send(tbl[2].ir, 1'b0);
      send(tbl[3].ir, 1'b0);
      drain();

      // Counter saturation
      for (int i = 0; i < 19; i++) send(32'h0000007F, 1'b0);
      drain();
      chk("sat_a", 64'(ill_count_a), 64'hF);
      chk("sat_c", 64'(ill_count_c), 64'hF);
      rst = 1'b1;
      step(1'b0, 32'h0, 1'b0, 1'b0);
      rst = 1'b0;
      chk("sat_clear_a", 64'(ill_count_a), 64'd0);
      chk("sat_clear_c", 64'(ill_count_c), 64'd0);

      // Flush while the stage could accept: the illegal input must vanish uncounted
      step(1'b1, tbl[0].ir, 1'b0, 1'b0);
      step(1'b1, 32'h0000007F, 1'b0, 1'b1);
      chk("flush1_vld", 64'(out_valid_a), 64'd0);
      chk("flush1_rdy", 64'(in_ready_a), 64'd1);
      chk("flush1_cnt", 64'(ill_count_a), 64'd0);

      // Flush with skid full
      step(1'b1, tbl[0].ir, 1'b0, 1'b0);
      step(1'b1, 32'h0000007F, 1'b0, 1'b0);
      chk("flush2_full", 64'(in_ready_a), 64'd0);
      step(1'b1, 32'h0000007F, 1'b0, 1'b1);
      chk("flush2_vld", 64'(out_valid_a), 64'd0);
      chk("flush2_rdy", 64'(in_ready_a), 64'd1);
      chk("flush2_cnt", 64'(ill_count_a), 64'd1);
      cnt32 = 1;
      cnt64 = 1;
      send(tbl[5].ir, 1'b0);
      drain();

      // Reset in the middle of a stall
      step(1'b1, tbl[1].ir, 1'b0, 1'b0);
      step(1'b1, 32'h0000007F, 1'b0, 1'b0);
      rst = 1'b1;
      step(1'b1, tbl[2].ir, 1'b1, 1'b1);
      rst = 1'b0;
      reset_checks("midrst");
      send(tbl[9].ir, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
